// File: rtl/hsl_share_arb_pkg.sv
// hsl_arb_pkg: shared types and constants for the HSL converter arbiter.
// Pixel/result words are {R,G,B} and {H,S,L}, 8 bits each, MSB first.
package hsl_arb_pkg;

  localparam int   HSL_LATENCY = 23;
  localparam logic REQ_ID_0    = 1'b0;
  localparam logic REQ_ID_1    = 1'b1;

  typedef logic [23:0] rgb_t;
  typedef logic [23:0] hsl_t;

  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } own_e;

  function automatic own_e own_flip(own_e o);
    return (o == OWN0) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/hsl_share_arb_if.sv
// hsl_share_arb_if: requester, converter and result signals of the arbiter.
// slave is the arbiter side, master is the environment side.
interface hsl_share_arb_if;
  import hsl_arb_pkg::*;

  logic req0_valid;
  rgb_t req0_rgb;
  logic req0_ready;
  logic req1_valid;
  rgb_t req1_rgb;
  logic req1_ready;
  logic pause;

  logic       conv_en;
  logic [7:0] conv_r;
  logic [7:0] conv_g;
  logic [7:0] conv_b;
  logic       conv_hsl_en;
  logic [7:0] conv_h;
  logic [7:0] conv_s;
  logic [7:0] conv_l;

  logic out0_valid;
  hsl_t out0_hsl;
  logic out1_valid;
  hsl_t out1_hsl;
  logic idle;
  logic err;

  modport slave (
    input  req0_valid, req0_rgb,
    input  req1_valid, req1_rgb,
    input  pause,
    input  conv_hsl_en, conv_h, conv_s, conv_l,
    output req0_ready, req1_ready,
    output conv_en, conv_r, conv_g, conv_b,
    output out0_valid, out0_hsl,
    output out1_valid, out1_hsl,
    output idle, err
  );

  modport master (
    output req0_valid, req0_rgb,
    output req1_valid, req1_rgb,
    output pause,
    output conv_hsl_en, conv_h, conv_s, conv_l,
    input  req0_ready, req1_ready,
    input  conv_en, conv_r, conv_g, conv_b,
    input  out0_valid, out0_hsl,
    input  out1_valid, out1_hsl,
    input  idle, err
  );

endinterface

// File: rtl/hsl_share_arb_tag.sv
// hsl_tag_pipe: delays issue tags so the tail lines up with the converter
// result strobe; stage 0 mirrors conv_en, the tail is LATENCY cycles later.
module hsl_tag_pipe
  import hsl_arb_pkg::*;
#(
  parameter int LATENCY = HSL_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tail,
  output logic any_valid
);

  tag_t stage [LATENCY+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= LATENCY; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i <= LATENCY; i++)
        stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i <= LATENCY; i++)
      any_valid = any_valid | stage[i].vld;
  end

  assign tail = stage[LATENCY];

endmodule

// File: rtl/hsl_share_arb.sv
// hsl_share_arb: shares one RGB->HSL converter between two requesters with
// burst-limited round-robin issue and tag-steered result return.
module hsl_share_arb
  import hsl_arb_pkg::*;
#(
  parameter int LATENCY = HSL_LATENCY,
  parameter int BURST   = 16
) (
  input logic            clk,
  input logic            rst_n,
  hsl_share_arb_if.slave bus
);

  localparam int         GW      = $clog2(LATENCY + 1);
  localparam logic [7:0] BURST_C = 8'(BURST);

  own_e       state;
  own_e       state_nxt;
  logic [7:0] burst_cnt;
  logic [7:0] cnt_nxt;

  logic own_v;
  logic oth_v;
  logic g_own;
  logic g_oth;
  logic gnt0;
  logic gnt1;
  logic gnt_any;

  logic conv_en_q;
  rgb_t conv_rgb_q;

  tag_t tag_in;
  tag_t tail;
  logic any_valid;

  logic [GW-1:0] guard_cnt;
  logic          guard;
  logic          hit;
  logic          mis;
  hsl_t          res;

  logic out0_v;
  logic out1_v;
  hsl_t out0_q;
  hsl_t out1_q;
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OWN0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = burst_cnt;
    unique case (1'b1)
      g_oth: begin
        state_nxt = own_flip(state);
        cnt_nxt   = 8'd1;
      end
      g_own: begin
        cnt_nxt = (burst_cnt < BURST_C) ?
                  burst_cnt + 8'd1 : BURST_C;
      end
      default: ;
    endcase
  end

  // The current owner keeps the port until its burst is spent while the
  // other side waits; an idle owner hands over immediately.
  always_comb begin
    own_v = (state == OWN1) ? bus.req1_valid
                            : bus.req0_valid;
    oth_v = (state == OWN1) ? bus.req0_valid
                            : bus.req1_valid;
    g_own = !bus.pause && own_v &&
            (!oth_v || (burst_cnt < BURST_C));
    g_oth = !bus.pause && oth_v && !g_own;
    gnt0  = (state == OWN0) ? g_own : g_oth;
    gnt1  = (state == OWN1) ? g_own : g_oth;
  end

  assign gnt_any = gnt0 | gnt1;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_en_q  <= 1'b0;
      conv_rgb_q <= '0;
    end else begin
      conv_en_q <= gnt_any;
      if (gnt_any)
        conv_rgb_q <= gnt1 ? bus.req1_rgb
                           : bus.req0_rgb;
    end
  end

  assign bus.conv_en = conv_en_q;
  assign bus.conv_r  = conv_rgb_q[23:16];
  assign bus.conv_g  = conv_rgb_q[15:8];
  assign bus.conv_b  = conv_rgb_q[7:0];

  assign tag_in = '{vld: gnt_any,
                    id:  gnt1 ? REQ_ID_1 : REQ_ID_0};

  hsl_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_in    (tag_in),
    .tail      (tail),
    .any_valid (any_valid)
  );

  // Stale converter output may still arrive right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      guard_cnt <= GW'(LATENCY);
    else if (guard_cnt != '0)
      guard_cnt <= guard_cnt - GW'(1);
  end

  assign guard = (guard_cnt != '0);
  assign hit   = !guard && tail.vld && bus.conv_hsl_en;
  assign mis   = !guard && (tail.vld != bus.conv_hsl_en);
  assign res   = {bus.conv_h, bus.conv_s, bus.conv_l};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_v <= 1'b0;
      out1_v <= 1'b0;
      out0_q <= '0;
      out1_q <= '0;
      err_q  <= 1'b0;
    end else begin
      out0_v <= hit && (tail.id == REQ_ID_0);
      out1_v <= hit && (tail.id == REQ_ID_1);
      if (hit && (tail.id == REQ_ID_0))
        out0_q <= res;
      if (hit && (tail.id == REQ_ID_1))
        out1_q <= res;
      if (mis)
        err_q <= 1'b1;
    end
  end

  assign bus.out0_valid = out0_v;
  assign bus.out1_valid = out1_v;
  assign bus.out0_hsl   = out0_q;
  assign bus.out1_hsl   = out1_q;
  assign bus.err        = err_q;
  assign bus.idle       = !conv_en_q && !any_valid;

endmodule

// File: tb/tb_hsl_share_arb.sv
// tb_hsl_share_arb: scoreboard bench, two arbiters (BURST 16 and BURST 1)
// each fed by a fixed-latency converter model.
`timescale 1ns/1ps
module tb_hsl_share_arb;
  import hsl_arb_pkg::*;

  localparam int LAT = HSL_LATENCY;

  typedef struct {
    hsl_t hsl;
    int   due;
  } exp_t;

  typedef struct packed {
    logic en;
    logic early;
    hsl_t hsl;
  } cv_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   inject = 1'b0;
  int   pix [2][2];
  int   last_hs;
  exp_t q [4][$];

  cv_t cv0 [LAT];
  cv_t cv1 [LAT];

  hsl_share_arb_if bus0 ();
  hsl_share_arb_if bus1 ();

  hsl_share_arb #(.LATENCY(LAT), .BURST(16)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  hsl_share_arb #(.LATENCY(LAT), .BURST(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic hsl_t conv_f(rgb_t c);
    return {c[23:16] ^ 8'h5A, c[15:8] + 8'd3, ~c[7:0]};
  endfunction

  function automatic rgb_t src_rgb(int r, int n);
    if (r == 0 && n < 4) begin
      case (n)
        0:       return 24'h0A141E;
        1:       return 24'hFF0000;
        2:       return 24'h00FF00;
        default: return 24'h070707;
      endcase
    end
    return {(r == 1) ? 8'hC0 : 8'h40, 8'(n), 8'(n + 32)};
  endfunction

  // converter models: fixed latency, bus0 can emit one strobe early
  always @(posedge clk) begin
    cv0[0] <= '{en: bus0.conv_en, early: inject,
                hsl: conv_f({bus0.conv_r, bus0.conv_g,
                             bus0.conv_b})};
    cv1[0] <= '{en: bus1.conv_en, early: 1'b0,
                hsl: conv_f({bus1.conv_r, bus1.conv_g,
                             bus1.conv_b})};
    for (int i = 1; i < LAT; i++) begin
      cv0[i] <= cv0[i-1];
      cv1[i] <= cv1[i-1];
    end
  end

  wire e0 = cv0[LAT-2].en && cv0[LAT-2].early;
  assign bus0.conv_hsl_en =
    (cv0[LAT-1].en && !cv0[LAT-1].early) || e0;
  assign {bus0.conv_h, bus0.conv_s, bus0.conv_l} =
    e0 ? cv0[LAT-2].hsl : cv0[LAT-1].hsl;
  assign bus1.conv_hsl_en = cv1[LAT-1].en;
  assign {bus1.conv_h, bus1.conv_s, bus1.conv_l} =
    cv1[LAT-1].hsl;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h",
               nm, act, exp);
    end
  endtask

  task automatic mon(int idx, logic v, hsl_t hsl);
    exp_t e;
    if (v) begin
      if (q[idx].size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL spurious_out idx%0d c%0d: got hsl %h, required none",
                 idx, cyc, hsl);
      end else begin
        e = q[idx].pop_front();
        chk($sformatf("hsl idx%0d c%0d", idx, cyc),
            32'(hsl), 32'(e.hsl));
        chk($sformatf("due idx%0d", idx),
            32'(cyc), 32'(e.due));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.out0_valid, bus0.out0_hsl);
    mon(1, bus0.out1_valid, bus0.out1_hsl);
    mon(2, bus1.out0_valid, bus1.out0_hsl);
    mon(3, bus1.out1_valid, bus1.out1_hsl);
  end

  // One cycle of stimulus; eg is the expected grant (-1 none).
  task automatic step(int inst, bit v0, bit v1, bit p,
                      int eg, bit push);
    rgb_t r0;
    rgb_t r1;
    logic g0;
    logic g1;
    @(negedge clk);
    r0 = src_rgb(0, pix[inst][0]);
    r1 = src_rgb(1, pix[inst][1]);
    if (inst == 0) begin
      bus0.req0_valid = v0;
      bus0.req0_rgb   = r0;
      bus0.req1_valid = v1;
      bus0.req1_rgb   = r1;
      bus0.pause      = p;
    end else begin
      bus1.req0_valid = v0;
      bus1.req0_rgb   = r0;
      bus1.req1_valid = v1;
      bus1.req1_rgb   = r1;
      bus1.pause      = p;
    end
    #1;
    g0 = (inst == 0) ? bus0.req0_ready : bus1.req0_ready;
    g1 = (inst == 0) ? bus0.req1_ready : bus1.req1_ready;
    chk($sformatf("ready0 i%0d c%0d", inst, cyc),
        32'(g0), 32'(eg == 0));
    chk($sformatf("ready1 i%0d c%0d", inst, cyc),
        32'(g1), 32'(eg == 1));
    if (push && eg >= 0)
      q[inst*2+eg].push_back('{hsl: conv_f((eg == 1) ? r1 : r0),
                               due: cyc + LAT + 2});
    if (v0 && g0) pix[inst][0]++;
    if (v1 && g1) pix[inst][1]++;
  endtask

  task automatic idle_steps(int inst, int n);
    for (int i = 0; i < n; i++)
      step(inst, 1'b0, 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) q[i].delete();
    for (int i = 0; i < 2; i++) begin
      pix[i][0] = 0;
      pix[i][1] = 0;
    end
    chk("rst conv_en", 32'(bus0.conv_en), 32'(0));
    chk("rst conv_rgb",
        32'({bus0.conv_r, bus0.conv_g, bus0.conv_b}), 32'(0));
    chk("rst out0_valid", 32'(bus0.out0_valid), 32'(0));
    chk("rst out1_valid", 32'(bus0.out1_valid), 32'(0));
    chk("rst out0_hsl", 32'(bus0.out0_hsl), 32'(0));
    chk("rst out1_hsl", 32'(bus0.out1_hsl), 32'(0));
    chk("rst err", 32'(bus0.err), 32'(0));
    chk("rst idle", 32'(bus0.idle), 32'(1));
    chk("rst b1 idle", 32'(bus1.idle), 32'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_drained(string nm);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s left idx%0d", nm, i),
          32'(q[i].size()), 32'(0));
  endtask

  initial begin
    bus0.req0_valid = 1'b0;
    bus0.req0_rgb   = '0;
    bus0.req1_valid = 1'b0;
    bus0.req1_rgb   = '0;
    bus0.pause      = 1'b0;
    bus1.req0_valid = 1'b0;
    bus1.req0_rgb   = '0;
    bus1.req1_valid = 1'b0;
    bus1.req1_rgb   = '0;
    bus1.pause      = 1'b0;

    // single requester, four directed pixels
    do_reset();
    for (int k = 0; k < 4; k++)
      step(0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle_steps(0, 30);
    chk("single err", 32'(bus0.err), 32'(0));
    chk("single idle", 32'(bus0.idle), 32'(1));
    chk_drained("single");

    // contention, BURST 16: 16 x req0, 16 x req1, 8 x req0
    do_reset();
    for (int k = 0; k < 40; k++)
      step(0, 1'b1, 1'b1, 1'b0,
           (k < 16 || k >= 32) ? 0 : 1, 1'b1);
    idle_steps(0, 30);
    chk("burst16 err", 32'(bus0.err), 32'(0));
    chk_drained("burst16");

    // BURST 1: strict alternation
    do_reset();
    for (int k = 0; k < 20; k++)
      step(1, 1'b1, 1'b1, 1'b0, k % 2, 1'b1);
    idle_steps(1, 30);
    chk("burst1 err", 32'(bus1.err), 32'(0));
    chk_drained("burst1");

    // pause after five handshakes, valid held high
    do_reset();
    for (int k = 0; k < 5; k++)
      step(0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    last_hs = cyc;
    for (int k = 0; k < 35; k++) begin
      step(0, 1'b1, 1'b0, 1'b1, -1, 1'b1);
      if (cyc == last_hs + LAT + 1)
        chk("pause idle early", 32'(bus0.idle), 32'(0));
      if (cyc == last_hs + LAT + 2)
        chk("pause idle rise", 32'(bus0.idle), 32'(1));
    end
    chk_drained("pause");
    for (int k = 0; k < 2; k++)
      step(0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle_steps(0, 30);
    chk_drained("unpause");

    // one strobe arrives a cycle early
    do_reset();
    step(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    inject = 1'b1;
    step(0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    inject = 1'b0;
    chk("mis err before", 32'(bus0.err), 32'(0));
    idle_steps(0, 28);
    chk("mis err set", 32'(bus0.err), 32'(1));
    for (int k = 0; k < 2; k++)
      step(0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle_steps(0, 30);
    chk("mis err sticky", 32'(bus0.err), 32'(1));
    chk_drained("mis");

    // reset with pixels in flight, stale strobes afterwards
    do_reset();
    for (int k = 0; k < 10; k++)
      step(0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_steps(0, 3);
    do_reset();
    for (int k = 0; k < LAT; k++) begin
      idle_steps(0, 1);
      chk($sformatf("guard err %0d", k),
          32'(bus0.err), 32'(0));
    end
    for (int k = 0; k < 3; k++)
      step(0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle_steps(0, 30);
    chk("post rst err", 32'(bus0.err), 32'(0));
    chk_drained("post rst");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hsl_share_arb.md
Name: hsl_share_arb

Overview:
- Shares one RGB-to-HSL converter between two pixel requesters, e.g. two camera streams.
- Arbitrates one pixel per cycle into the converter using burst-limited round-robin.
- Tags every issued pixel and steers each HSL result back to its owner when the converter returns it after its fixed latency.
- Sits between the stream front-ends and the converter instance. Also provides pause/idle sequencing and a sticky alignment-error flag.

Parameters:
- LATENCY, 23, converter latency in cycles from conv_en to conv_hsl_en.
- BURST, 16, maximum consecutive grants to one requester while the other is waiting (range 1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a pixel.
- req0_rgb  in  24  {R,G,B}, 8 bits each, R in [23:16].
- req0_ready  out  1  requester 0 pixel accepted this cycle.
- req1_valid / req1_rgb / req1_ready: same as requester 0, for requester 1.
- pause  in  1  when 1, no new grants; in-flight pixels drain.
- conv_en  out  1  pixel strobe to converter.
- conv_r / conv_g / conv_b  out  8 each  pixel to converter.
- conv_hsl_en  in  1  converter result strobe.
- conv_h / conv_s / conv_l  in  8 each  converter result.
- out0_valid  out  1  HSL result for requester 0.
- out0_hsl  out  24  {H,S,L}, H in [23:16].
- out1_valid / out1_hsl: same as requester 0, for requester 1.
- idle  out  1  no pixel in flight and conv_en low.
- err  out  1  sticky tag/strobe misalignment.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - conv_en = 0, conv_r/g/b = 0.
  - out0_valid = out1_valid = 0, out0_hsl = out1_hsl = 0.
  - err = 0, idle = 1.
  - owner = 0, burst_cnt = 0, all tag-pipe entries invalid.
- Arbitration (combinational grant, evaluated every cycle):
  - pause = 1: no grant; both ready = 0.
  - Owner is granted if owner valid and (other not valid, or burst_cnt < BURST).
  - Otherwise the other requester is granted if valid.
  - reqN_ready = grantN. A handshake is valid && ready in the same cycle.
- State update on a grant:
  - Grant to owner: burst_cnt <= min(burst_cnt+1, BURST).
  - Grant to other: owner <= other, burst_cnt <= 1.
  - No grant: owner and burst_cnt hold.
- Issue: conv_en <= any grant; conv_rgb <= granted rgb (holds its value when there is no grant). Issue occurs 1 cycle after the handshake.
- Tag pipe:
  - Entry {vld, id} is pushed at the same edge as conv_en, so it is aligned with conv_en.
  - The pipe delays entries by exactly LATENCY cycles. The tail entry is compared against conv_hsl_en in the same cycle.
- Result steering:
  - Tail vld && conv_hsl_en: out{id}_valid <= 1 and out{id}_hsl <= {conv_h, conv_s, conv_l} on the next edge. The other out_valid is 0.
  - out_hsl holds its last value when out_valid is 0.
- Total latency from handshake to outN_valid: LATENCY+2 cycles (25 at default). Throughput is 1 pixel/cycle. Outputs cannot be back-pressured.
- Misalignment:
  - Tail vld != conv_hsl_en sets err = 1; it is cleared only by reset.
  - Tail vld without conv_hsl_en: no output.
  - conv_hsl_en without tail vld: result dropped.
- Post-reset guard:
  - For LATENCY cycles after rst_n deasserts, conv_hsl_en is ignored and err is not set. This covers stale data still inside the converter pipeline.
  - A guard counter of width clog2(LATENCY+1) tracks this window.
- idle = !conv_en && no vld bit set anywhere in the tag pipe.
- pause asserted mid-stream: the grant stops the same cycle and in-flight results still emerge. idle rises LATENCY+1 cycles after the last conv_en.
- Both requesters valid with BURST = 1: strict alternation.

Decomposition:
- Package hsl_arb_pkg holds:
  - constants HSL_LATENCY = 23 and REQ_ID_0 = 1'b0, REQ_ID_1 = 1'b1.
  - typedef rgb_t (24 bits), hsl_t (24 bits), tag_t {logic vld; logic id}.
- Sub-module hsl_tag_pipe(LATENCY): async-reset shift register of tag_t. Outputs are the tail entry and an any_valid OR-reduction, which drives idle.
- The converter itself is instantiated by the parent, not inside this block.

Test Plan:
- Single requester: req0 streams 4 pixels (10,20,30), (255,0,0), (0,255,0), (7,7,7) back-to-back with a converter model of LATENCY 23 → out0_valid pulses on cycles 25..28 after the first handshake, in order; out1_valid stays 0; err = 0.
- Contention, BURST = 16: both valid continuously for 40 cycles → grants are req0 ×16, req1 ×16, req0 ×8. Results return with matching ids and values 25 cycles later.
- BURST = 1, both valid → grants strictly alternate 0,1,0,1… and out0/out1 results interleave with the same pattern.
- Pause: assert pause after 5 req0 handshakes while valid stays high → ready = 0 immediately. 5 results emerge, idle rises 24 cycles after the last conv_en, and no further grant occurs until pause = 0.
- Misalignment: inject conv_hsl_en one cycle early for a single pixel → err = 1 and stays set; the spurious strobe is dropped; outN_valid = 0 on the missing-strobe cycle.
- Reset mid-stream: assert rst_n low with 10 pixels in flight, release, and keep the converter model emitting stale strobes for 23 cycles → all outputs at reset values, no out_valid and err = 0 during the guard window. New traffic works afterwards.
